fifo_ram_syn: RTL and testbench
===============================

Name: fifo_ram_syn

Overview:
- Single-clock synchronous FIFO built on a small register-file RAM, with depth 2**ADDR_WIDTH (8 entries by default).
- Provides a first-word-fall-through read port and registered full/empty flags.
- Used as a generic rate/ordering buffer between two blocks in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 3, address width; FIFO depth = 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising clk.
- rd  input  1  read/pop request; consumes the head word when honoured.
- wr  input  1  write/push request; stores w_data when honoured.
- w_data  input  DATA_WIDTH  write data.
- r_data  output  DATA_WIDTH  head-of-FIFO word (first-word fall-through).
- empty  output  1  FIFO holds 0 words.
- full  output  1  FIFO holds 2**ADDR_WIDTH words.

Behaviour:
- Reset (synchronous, active-high, clk and reset only) clears the following:
  - write pointer and read pointer to 0;
  - empty=1, full=0;
  - all storage entries to 0, so r_data=0 after reset.
- Reset asserted mid-operation discards all contents at that edge; rd/wr are ignored in a reset cycle.
- Storage write: mem[w_ptr] <= w_data on the rising edge when the write is honoured.
- r_data = mem[r_ptr], combinational from the current read pointer; no read latency.
  - Head word is visible the cycle after it is written into an empty FIFO.
  - When empty, r_data shows mem[r_ptr], which is stale; it is not meaningful and the bench does not check it.
- Pointers are ADDR_WIDTH bits, increment by 1 and wrap naturally from 2**ADDR_WIDTH-1 to 0.
- full/empty are registered flags updated per {wr,rd}:
  - 00: no change.
  - 10 (write only): ignored if full. Otherwise write, w_ptr++, empty<=0, full<=1 if w_ptr+1==r_ptr.
  - 01 (read only): ignored if empty. Otherwise r_ptr++, full<=0, empty<=1 if r_ptr+1==w_ptr.
  - 11 when empty: acts as write only; the read is ignored. Next cycle empty=0 and the written word is on r_data.
  - 11 when full: both proceed. The head is consumed and the new word is written into the freed slot (w_ptr==r_ptr). Both pointers advance, full stays 1.
  - 11 otherwise: both proceed, both pointers advance, flags unchanged.
- Overflow (wr when full with rd=0) and underflow (rd when empty) are silently dropped: no state change, no error output.
- full and empty are never both 1.

Decomposition:
- Shared package fifo_pkg: default constants FIFO_DATA_WIDTH=8 and FIFO_ADDR_WIDTH=3. No typedefs are needed.
- Sub-module fifo_reg_file: parameterised storage array.
  - Synchronous write port (wr_en, w_addr, w_data).
  - Asynchronous read port (r_addr, r_data).
  - Synchronous reset clear.
- Top fifo_ram_syn contains the pointer/flag controller and instantiates fifo_reg_file.
  - Write enable to fifo_reg_file = wr & (~full | rd).

Test Plan:
- Reset → empty=1, full=0, r_data=0; rd=1 while empty leaves empty=1 and the pointers unchanged.
- Simultaneous wr=rd=1 from empty, 8 random words streamed:
  - cycle 1 is write only;
  - afterwards empty=0 and full=0 throughout;
  - r_data equals the word written the previous cycle.
- Write 8 words 0x11..0x88 with rd=0:
  - full=1 after the 8th edge, empty=0;
  - a 9th write of 0xFF is dropped and r_data stays 0x11.
- From full, rd=1 for 8 cycles: r_data sequence is 0x11,0x22,…,0x88, full drops after the 1st read, and empty=1 after the 8th.
- Pointer wrap:
  - write 5 words, read 5, then write 8 (0xA0..0xA7) so pointers wrap;
  - then read 8 → order 0xA0..0xA7, and full/empty are correct at each boundary.
- From full, wr=rd=1 with w_data=0x5A:
  - full stays 1 and the old head is popped;
  - after draining 7 words, 0x5A is the final word read;
  - reset asserted mid-stream → next cycle empty=1, full=0, r_data=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults for the register-file FIFO.
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 3;
endpackage

// File: rtl/fifo_reg_file.sv
// Register-file storage: synchronous write, asynchronous read, synchronous clear.
module fifo_reg_file
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];
endmodule

// File: rtl/fifo_ram_syn.sv
// Single-clock FWFT FIFO: pointer/flag controller around fifo_reg_file.
module fifo_ram_syn
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full
);
    logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
    logic [ADDR_WIDTH-1:0] w_succ, r_succ;
    logic                  wr_en;

    assign w_succ = w_ptr + 1'b1;
    assign r_succ = r_ptr + 1'b1;
    // When full, a simultaneous read frees the head slot that w_ptr now points at.
    assign wr_en  = wr & (~full | rd);

    fifo_reg_file #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_reg_file (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .w_addr (w_ptr),
        .w_data (w_data),
        .r_addr (r_ptr),
        .r_data (r_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            unique case ({wr, rd})
                2'b10: begin
                    if (!full) begin
                        w_ptr <= w_succ;
                        empty <= 1'b0;
                        full  <= (w_succ == r_ptr);
                    end
                end
                2'b01: begin
                    if (!empty) begin
                        r_ptr <= r_succ;
                        full  <= 1'b0;
                        empty <= (r_succ == w_ptr);
                    end
                end
                2'b11: begin
                    // An empty FIFO has no head to pop, so this degrades to a plain write.
                    if (empty) begin
                        w_ptr <= w_succ;
                        empty <= 1'b0;
                        full  <= (w_succ == r_ptr);
                    end else begin
                        w_ptr <= w_succ;
                        r_ptr <= r_succ;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_ram_syn.sv
// Directed self-checking bench for fifo_ram_syn.
module tb_fifo_ram_syn;
    logic       clk = 1'b0;
    logic       reset;
    logic       rd;
    logic       wr;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       empty;
    logic       full;

    int checks = 0;
    int errors = 0;

    logic [7:0] stream_words [8] = '{8'h3C, 8'hE1, 8'h07, 8'h9B, 8'h42, 8'hD5, 8'h6E, 8'hF0};

    fifo_ram_syn #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .w_data (w_data),
        .r_data (r_data),
        .empty  (empty),
        .full   (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rd = 1'b0; wr = 1'b0; w_data = 8'h00;
        #1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rdata", 32'(r_data), 32'h00);

        // underflow ignored
        rd = 1'b1;
        tick();
        idle();
        check("uf_empty", 32'(empty), 32'd1);
        check("uf_full", 32'(full), 32'd0);

        // streaming wr=rd=1 from empty
        wr = 1'b1; rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_data = stream_words[i];
            tick();
            check($sformatf("stream_empty%0d", i), 32'(empty), 32'd0);
            check($sformatf("stream_full%0d", i), 32'(full), 32'd0);
            check($sformatf("stream_rdata%0d", i), 32'(r_data), 32'(stream_words[i]));
        end
        wr = 1'b0;
        tick();
        rd = 1'b0;
        check("stream_drained", 32'(empty), 32'd1);

        // fill 0x11..0x88
        wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_data = 8'((i + 1) * 8'h11);
            tick();
            check($sformatf("fill_empty%0d", i), 32'(empty), 32'd0);
            check($sformatf("fill_full%0d", i), 32'(full), (i == 7) ? 32'd1 : 32'd0);
            check($sformatf("fill_head%0d", i), 32'(r_data), 32'h11);
        end
        w_data = 8'hFF;
        tick();
        wr = 1'b0;
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_head", 32'(r_data), 32'h11);

        // drain 8
        rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_rdata%0d", i), 32'(r_data), 32'((i + 1) * 8'h11));
            tick();
            check($sformatf("drain_full%0d", i), 32'(full), 32'd0);
            check($sformatf("drain_empty%0d", i), 32'(empty), (i == 7) ? 32'd1 : 32'd0);
        end
        rd = 1'b0;

        // pointer wrap: write 5, read 5, write 8, read 8
        wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_data = 8'(i + 1);
            tick();
        end
        wr = 1'b0; rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wrap_pre%0d", i), 32'(r_data), 32'(i + 1));
            tick();
        end
        rd = 1'b0;
        check("wrap_pre_empty", 32'(empty), 32'd1);
        wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_data = 8'(8'hA0 + i);
            tick();
            check($sformatf("wrap_wfull%0d", i), 32'(full), (i == 7) ? 32'd1 : 32'd0);
        end
        wr = 1'b0; rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wrap_rdata%0d", i), 32'(r_data), 32'(8'hA0 + i));
            tick();
            check($sformatf("wrap_rfull%0d", i), 32'(full), 32'd0);
            check($sformatf("wrap_rempty%0d", i), 32'(empty), (i == 7) ? 32'd1 : 32'd0);
        end
        rd = 1'b0;

        // simultaneous rd/wr while full
        wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_data = 8'(8'hB0 + i);
            tick();
        end
        check("sim_pre_full", 32'(full), 32'd1);
        rd = 1'b1; w_data = 8'h5A;
        tick();
        wr = 1'b0;
        check("sim_full", 32'(full), 32'd1);
        check("sim_head", 32'(r_data), 32'hB1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("sim_drain%0d", i), 32'(r_data), 32'(8'hB1 + i));
            tick();
        end
        rd = 1'b0;
        check("sim_last", 32'(r_data), 32'h5A);
        check("sim_last_empty", 32'(empty), 32'd0);
        check("sim_last_full", 32'(full), 32'd0);

        // reset mid-stream with traffic present
        wr = 1'b1; rd = 1'b1; w_data = 8'hC3; reset = 1'b1;
        tick();
        reset = 1'b0; idle();
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_rdata", 32'(r_data), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
